// File: rtl/axi_axis_reader.sv
// AXI4-Lite slave that buffers an AXI4-Stream into a FIFO and lets software
// pop it one word at a time through DATA, with fill level and flags in STATUS.
module axi_axis_reader #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,

    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        R_IDLE,
        R_RESP
    } read_state_t;

    read_state_t read_state;

    logic [AXI_DATA_WIDTH-1:0] fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic ar_fire;
    logic underflow;
    logic underflow_set;
    logic underflow_clr;
    logic [AXI_DATA_WIDTH-1:0] status_word;

    logic aw_latched;
    logic aw_bit2_q;
    logic w_latched;
    logic w_bit24_q;
    logic aw_fire;
    logic w_fire;
    logic wr_addr_bit2;
    logic wr_data_bit24;
    logic wr_exec;
    logic bvalid_q;

    logic unused_bits;

    assign full          = (count == FULL_COUNT);
    assign empty         = (count == '0);
    assign s_axis_tready = !full;
    assign push          = s_axis_tvalid && !full;

    assign s_axi_arready = (read_state == R_IDLE);
    assign s_axi_rvalid  = (read_state == R_RESP);
    assign s_axi_rresp   = 2'b00;
    assign ar_fire       = s_axi_arvalid && (read_state == R_IDLE);
    assign pop           = ar_fire && !s_axi_araddr[2] && !empty;
    assign underflow_set = ar_fire && !s_axi_araddr[2] && empty;

    assign status_word = {7'd0, underflow, 6'd0, full, empty, 16'(count)};

    // Address and data of the executing write come from the latch if it was
    // captured earlier, otherwise straight from the channel in this cycle.
    assign s_axi_awready = !aw_latched && !bvalid_q;
    assign s_axi_wready  = !w_latched && !bvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign aw_fire       = s_axi_awvalid && s_axi_awready;
    assign w_fire        = s_axi_wvalid && s_axi_wready;
    assign wr_addr_bit2  = aw_latched ? aw_bit2_q : s_axi_awaddr[2];
    assign wr_data_bit24 = w_latched ? w_bit24_q : s_axi_wdata[24];
    assign wr_exec       = (aw_latched || aw_fire) && (w_latched || w_fire);
    assign underflow_clr = wr_exec && wr_addr_bit2 && wr_data_bit24;

    assign unused_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:3], s_axi_awaddr[1:0],
                           s_axi_araddr[AXI_ADDR_WIDTH-1:3], s_axi_araddr[1:0],
                           s_axi_wdata[AXI_DATA_WIDTH-1:25], s_axi_wdata[23:0]};

    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Read data is captured at the AR handshake and held until rready.
    always_ff @(posedge aclk) begin
        if (areset) begin
            read_state  <= R_IDLE;
            s_axi_rdata <= '0;
        end else begin
            case (read_state)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        read_state <= R_RESP;
                        if (s_axi_araddr[2]) begin
                            s_axi_rdata <= status_word;
                        end else if (empty) begin
                            s_axi_rdata <= '0;
                        end else begin
                            s_axi_rdata <= fifo_mem[rd_ptr];
                        end
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        read_state <= R_IDLE;
                    end
                end
                default: read_state <= R_IDLE;
            endcase
        end
    end

    // A set from an empty DATA read outranks a clear arriving in the same cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            underflow <= 1'b0;
        end else if (underflow_set) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_latched <= 1'b0;
            aw_bit2_q  <= 1'b0;
            w_latched  <= 1'b0;
            w_bit24_q  <= 1'b0;
            bvalid_q   <= 1'b0;
        end else begin
            if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            if (wr_exec) begin
                bvalid_q   <= 1'b1;
                aw_latched <= 1'b0;
                w_latched  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_latched <= 1'b1;
                    aw_bit2_q  <= s_axi_awaddr[2];
                end
                if (w_fire) begin
                    w_latched <= 1'b1;
                    w_bit24_q <= s_axi_wdata[24];
                end
            end
        end
    end

endmodule

// File: doc/axi_axis_reader.md
# axi_axis_reader

AXI4-Lite slave that buffers an incoming AXI4-Stream into a small FIFO and lets the processor read it one word at a time. It carries data in the opposite direction to our AXI-Lite-to-stream writer: PL stream producers feed it, and PS software drains it over the GP port. A status register exposes FIFO fill level, empty/full flags and a sticky underflow flag.

## Interface
- AXI_DATA_WIDTH, 32: AXI-Lite data width and stream tdata width; must be 32.
- AXI_ADDR_WIDTH, 32: AXI-Lite address width.
- FIFO_DEPTH_LOG2, 4: FIFO depth is 2^FIFO_DEPTH_LOG2 words; legal range 1–10.
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- s_axi_awaddr/awvalid/awready, wdata/wvalid/wready, bresp/bvalid/bready: AXI4-Lite write channels (widths per parameters, bresp 2).
- s_axi_araddr/arvalid/arready, rdata/rresp/rvalid/rready: AXI4-Lite read channels.
- s_axis_tdata  in  AXI_DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready; equals !full.

## Operation
- Address decode uses bit 2 only; all other address bits are ignored.
  - 0x0 DATA: a read pops one word.
  - 0x4 STATUS.
- STATUS layout:
  - [15:0] count (zero-extended, 0..2^N)
  - [16] empty
  - [17] full
  - [24] underflow (sticky)
  - all other bits 0.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo depth, plus a count register.
  - Push on s_axis_tvalid & s_axis_tready. A push while full is impossible because tready=0.
  - No fall-through: a word pushed in cycle t is readable from cycle t+1.
- Read FSM, two states:
  - R_IDLE: arready=1. On arvalid, latch rdata/rresp and go to R_RESP.
    - DATA with count>0: rdata=head, pop.
    - DATA with count==0: rdata=0, no pop, set underflow.
    - STATUS: rdata = STATUS value sampled in the handshake cycle.
  - R_RESP: arready=0, rvalid=1, rdata held stable. On rready, return to R_IDLE.
  - rresp is always 2'b00.
- Write path:
  - awready = !aw_latched & !bvalid; wready = !w_latched & !bvalid.
  - AW and W may arrive in any order or in the same cycle; each is latched independently.
  - When both are latched, the write executes and bvalid=1 next cycle; latches clear.
  - bvalid holds until bready, then clears.
  - A write to STATUS with wdata[24]=1 clears underflow. All other writes have no effect.
  - bresp is always 2'b00.
- Simultaneous push and pop (count>0): count unchanged, both pointers advance.
- Simultaneous underflow set and write-clear: set wins.

## Timing
- Reset values:
  - s_axi_arready=1, awready=1, wready=1
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0
  - s_axis_tready=1
  - count=0, pointers=0, underflow=0
  - Read FSM in R_IDLE, write latches clear.
- Reset mid-transaction: pending rvalid/bvalid drop the next cycle, the FIFO is flushed and latched AW/W are discarded.
- Read latency: AR handshake in cycle t gives rvalid=1 in cycle t+1. Minimum read period is 2 cycles (one outstanding read).
- Pop takes effect in the AR handshake cycle. count, full and tready reflect it in cycle t+1.
- Write latency: bvalid is asserted the cycle after the later of the AW and W handshakes.
- s_axis_tready is registered-derived (from count). From full, it reasserts the cycle after a pop.

## Test plan
- Reset, then push 0x11,0x22,0x33 and read 0x0 three times: rdata 0x11, 0x22, 0x33 in order. A following STATUS read returns 0x00010000 (empty=1, count=0).
- Push 16 words (N=4): tready=0 after the 16th push. STATUS returns 0x00020010. One DATA read → tready=1 next cycle, count=15.
- DATA read while empty: rdata=0, rresp=0, STATUS bit 24 set. Write 0x01000000 to 0x4 → STATUS bit 24 cleared, bvalid one cycle after the handshake.
- Continuous tvalid with back-to-back DATA reads and rready held low 3 cycles: rdata stable while rvalid=1, no extra pop, data order preserved across pointer wrap (≥40 words).
- W before AW (2-cycle gap), then AW and W in the same cycle: exactly one bvalid per write; awready/wready low while latched or bvalid pending.
- Assert areset while rvalid=1 and count=5: next cycle rvalid=0, count=0, tready=1. A subsequent DATA read sets underflow.
